msrv32_decode_buffer: RTL and testbench
=======================================

Name: msrv32_decode_buffer

Overview:
- Instruction decode buffer between fetch and the decode/immediate stage of the msrv32 core.
- Queues fetched instruction words with their PCs in a small FIFO.
- Presents the head entry pre-split into fields, plus the 3-bit imm_type code that selects the immediate format downstream.
- Decouples fetch from decode stalls and supports a single-cycle flush on redirect.

Parameters:
DEPTH, 2, number of FIFO entries; power of two, 2..8
NOP_WORD, 32'h00000013, word whose decode drives the field outputs when the buffer is empty (ADDI x0,x0,0)

Ports:
ms_riscv32_mp_clk_in  input  1  clock; all state updates on rising edge
ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
instr_in  input  32  fetched instruction word
pc_in  input  32  PC of instr_in
instr_valid_in  input  1  instr_in/pc_in valid
instr_ready_out  output  1  buffer can accept; equals (count < DEPTH)
flush_in  input  1  discard all entries (branch/jump redirect)
out_ready_in  input  1  downstream consumes head this cycle
out_valid_out  output  1  head entry valid; equals (count != 0)
instr_31_7_out  output  25  head instr[31:7], immediate generator source
opcode_out  output  7  head instr[6:0]
rd_addr_out  output  5  head instr[11:7]
funct3_out  output  3  head instr[14:12]
rs1_addr_out  output  5  head instr[19:15]
rs2_addr_out  output  5  head instr[24:20]
funct7_out  output  7  head instr[31:25]
imm_type_out  output  3  immediate format code for head
pc_out  output  32  PC of head
count_out  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous): count, rd_ptr and wr_ptr = 0; out_valid_out = 0; instr_ready_out = 1; field outputs = decode of NOP_WORD; pc_out = 0; storage contents are don't-care.
- Push when instr_valid_in && instr_ready_out. Pop when out_valid_out && out_ready_in.
- instr_ready_out depends only on the registered count. No combinational path from out_ready_in, so a push is never accepted at full even if a same-cycle pop occurs.
- Latency: a word pushed at edge N is visible on the outputs with out_valid_out = 1 after edge N; there is no same-cycle fall-through.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, both pointers advance, and order is preserved.
- Pointers wrap modulo DEPTH.
- Empty: field outputs show the NOP_WORD decode and pc_out = 0; out_ready_in is ignored.
- Flush: at the edge where flush_in = 1, count and both pointers clear. A push or pop in the same cycle is discarded, and the outputs show NOP after the edge.
- Flush while empty: no effect.
- imm_type_out decode from head opcode:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR -> 001
  - 0100011 STORE -> 010
  - 1100011 BRANCH -> 011
  - 0110111 LUI, 0010111 AUIPC -> 100
  - 1101111 JAL -> 101
  - 1110011 SYSTEM: funct3[2] = 1 -> 110, else 001
  - all others, including 0110011 OP -> 000
- Field outputs and imm_type_out are combinational from the registered head entry; imm_type_out is not stored in the FIFO.

Optional Feature:
MSRV32_ILLEGAL_DET_EN
- Defined: adds output port illegal_out (1 bit).
  - High when out_valid_out = 1 and either instr[1:0] != 2'b11 or the opcode is not one of the nine RV32I opcodes listed above plus 0110011 and 0001111 (MISC-MEM).
  - Low when empty and at reset.
  - An illegal entry is still popped normally.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-traffic with 2 entries held -> out_valid_out = 0, count_out = 0, opcode_out = 7'h13, imm_type_out = 3'b001, pc_out = 0, instr_ready_out = 1 immediately.
- DEPTH = 2: push 32'h00A00093 (pc 0) and 32'h00112223 (pc 4) with out_ready_in = 0 -> count_out = 2, instr_ready_out = 0; head imm_type_out = 001, rd_addr_out = 1; a third push is not accepted.
- Continue from the previous scenario: raise out_ready_in, pop one and push 32'h0000006F (pc 8) -> head becomes pc 4 with imm_type_out = 010, rs2_addr_out = 1; next pop shows pc 8 with imm_type_out = 101. Order is preserved across pointer wrap.
- Same-cycle push and pop at count = 1 with 32'h000012B7 -> count_out stays 1; next head is the LUI with imm_type_out = 100, rd_addr_out = 5.
- flush_in with count = 2 and a concurrent push -> after the edge, count_out = 0, out_valid_out = 0; the pushed word never appears at the outputs.
- With MSRV32_ILLEGAL_DET_EN: push 32'h30529073 (csrrw) -> illegal_out = 0, imm_type_out = 001; push 32'h00000000 -> illegal_out = 1.

Source files
------------

// File: rtl/msrv32_decode_buffer.sv
// msrv32_decode_buffer
//
// Instruction decode buffer between fetch and decode. Fetched words and
// their PCs are queued in a small FIFO. The head entry is presented split
// into RISC-V fields, together with the immediate-format code used
// downstream. Fetch and decode are decoupled, and a redirect flush empties
// the buffer in a single cycle.
//
// Optional build macro:
//   MSRV32_ILLEGAL_DET_EN  adds illegal_out, which flags a head word with a
//                          non-RV32I opcode.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in  clock, async active-high reset
//   instr_in, pc_in, instr_valid_in              fetch side push
//   instr_ready_out                              buffer not full
//   flush_in                                     discard all entries
//   out_ready_in, out_valid_out                  decode side pop handshake
//   instr_31_7_out .. funct7_out                 head instruction fields
//   imm_type_out                                 immediate format of head
//   pc_out                                       PC of head (0 when empty)
//   count_out                                    occupancy
//   illegal_out                                  (macro only) head is illegal
module msrv32_decode_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                     ms_riscv32_mp_clk_in,
    input  logic                     ms_riscv32_mp_rst_in,
    input  logic [31:0]              instr_in,
    input  logic [31:0]              pc_in,
    input  logic                     instr_valid_in,
    output logic                     instr_ready_out,
    input  logic                     flush_in,
    input  logic                     out_ready_in,
    output logic                     out_valid_out,
    output logic [24:0]              instr_31_7_out,
    output logic [6:0]               opcode_out,
    output logic [4:0]               rd_addr_out,
    output logic [2:0]               funct3_out,
    output logic [4:0]               rs1_addr_out,
    output logic [4:0]               rs2_addr_out,
    output logic [6:0]               funct7_out,
    output logic [2:0]               imm_type_out,
    output logic [31:0]              pc_out,
    output logic [$clog2(DEPTH):0]   count_out
`ifdef MSRV32_ILLEGAL_DET_EN
    ,
    output logic                     illegal_out
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic        push, pop;
    logic [31:0] head_word;

    // Ready comes only from registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign instr_ready_out = (count_q < DepthC);
    assign out_valid_out   = (count_q != '0);
    assign count_out       = count_q;

    assign push = instr_valid_in && instr_ready_out;
    assign pop  = out_valid_out && out_ready_in;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset here.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push && !flush_in) begin
            instr_mem_q[wr_ptr_q] <= instr_in;
            pc_mem_q[wr_ptr_q]    <= pc_in;
        end
    end

    assign head_word = out_valid_out ? instr_mem_q[rd_ptr_q] : NOP_WORD;
    assign pc_out    = out_valid_out ? pc_mem_q[rd_ptr_q]    : 32'h0;

    assign instr_31_7_out = head_word[31:7];
    assign opcode_out     = head_word[6:0];
    assign rd_addr_out    = head_word[11:7];
    assign funct3_out     = head_word[14:12];
    assign rs1_addr_out   = head_word[19:15];
    assign rs2_addr_out   = head_word[24:20];
    assign funct7_out     = head_word[31:25];

    always_comb begin
        imm_type_out = 3'b000;
        case (head_word[6:0])
            OpLoad, OpImm, OpJalr: imm_type_out = 3'b001;
            OpStore:               imm_type_out = 3'b010;
            OpBranch:              imm_type_out = 3'b011;
            OpLui, OpAuipc:        imm_type_out = 3'b100;
            OpJal:                 imm_type_out = 3'b101;
            // CSR immediate forms (funct3[2] set) use the zimm format.
            OpSystem:              imm_type_out = head_word[14] ? 3'b110 : 3'b001;
            default:               imm_type_out = 3'b000;
        endcase
    end

`ifdef MSRV32_ILLEGAL_DET_EN
    logic legal_op;

    always_comb begin
        legal_op = 1'b0;
        case (head_word[6:0])
            OpLoad, OpMisc, OpImm, OpAuipc, OpStore, OpReg, OpLui,
            OpBranch, OpJalr, OpJal, OpSystem: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign illegal_out = out_valid_out && ((head_word[1:0] != 2'b11) || !legal_op);
`endif

endmodule

// File: tb/tb_msrv32_decode_buffer.sv
module tb_msrv32_decode_buffer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned VW    = 94 + CW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        vld = 1'b0;
    logic        flsh = 1'b0;
    logic        ordy = 1'b0;

    logic          instr_ready_out, out_valid_out;
    logic [24:0]   instr_31_7_out;
    logic [6:0]    opcode_out, funct7_out;
    logic [4:0]    rd_addr_out, rs1_addr_out, rs2_addr_out;
    logic [2:0]    funct3_out, imm_type_out;
    logic [31:0]   pc_out;
    logic [CW-1:0] count_out;
`ifdef MSRV32_ILLEGAL_DET_EN
    logic          illegal_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the buffer is just an ordered list of (word, pc).
    logic [31:0] q_i[$];
    logic [31:0] q_p[$];

    always #5 clk = ~clk;

    msrv32_decode_buffer #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0013)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .instr_in             (instr_in),
        .pc_in                (pc_in),
        .instr_valid_in       (vld),
        .instr_ready_out      (instr_ready_out),
        .flush_in             (flsh),
        .out_ready_in         (ordy),
        .out_valid_out        (out_valid_out),
        .instr_31_7_out       (instr_31_7_out),
        .opcode_out           (opcode_out),
        .rd_addr_out          (rd_addr_out),
        .funct3_out           (funct3_out),
        .rs1_addr_out         (rs1_addr_out),
        .rs2_addr_out         (rs2_addr_out),
        .funct7_out           (funct7_out),
        .imm_type_out         (imm_type_out),
        .pc_out               (pc_out),
        .count_out            (count_out)
`ifdef MSRV32_ILLEGAL_DET_EN
        ,
        .illegal_out          (illegal_out)
`endif
    );

    // Immediate format from the opcode table.
    function automatic logic [2:0] exp_imm(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 3'd1;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h63) return 3'd3;
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        if (op == 7'h6F) return 3'd5;
        if (op == 7'h73) return w[14] ? 3'd6 : 3'd1;
        return 3'd0;
    endfunction

    function automatic logic exp_illegal(input logic [31:0] w, input bit valid);
        logic [6:0] op;
        bit ok;
        op = w[6:0];
        ok = (op == 7'h03) || (op == 7'h0F) || (op == 7'h13) || (op == 7'h17) ||
             (op == 7'h23) || (op == 7'h33) || (op == 7'h37) || (op == 7'h63) ||
             (op == 7'h67) || (op == 7'h6F) || (op == 7'h73);
        return valid && ((w[1:0] != 2'b11) || !ok);
    endfunction

    function automatic logic [31:0] head_w();
        return (q_i.size() != 0) ? q_i[0] : 32'h0000_0013;
    endfunction

    function automatic logic [31:0] head_pc();
        return (q_p.size() != 0) ? q_p[0] : 32'h0;
    endfunction

    // Advance one clock with current inputs and update the model.
    task automatic step();
        int sz;
        bit do_push, do_pop;
        sz      = q_i.size();
        do_push = vld && (sz < DEPTH);
        do_pop  = (sz != 0) && ordy;
        @(posedge clk);
        #1;
        if (flsh) begin
            q_i.delete();
            q_p.delete();
        end else begin
            if (do_pop) begin
                void'(q_i.pop_front());
                void'(q_p.pop_front());
            end
            if (do_push) begin
                q_i.push_back(instr_in);
                q_p.push_back(pc_in);
            end
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] p,
                         input bit r, input bit f);
        vld = v; instr_in = w; pc_in = p; ordy = r; flsh = f;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        q_i.delete();
        q_p.delete();
    endtask

    task automatic test_reset();
        drive(1, 32'h0000_0093, 32'h100, 0, 0);
        step();
        drive(1, 32'h0000_0113, 32'h104, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (count_out !== CW'(2)) begin
            n_err++; $display("FAIL reset_pre_count got %0d exp 2", count_out);
        end
        do_reset();
        n_cmp++;
        if ({out_valid_out, instr_ready_out, count_out, opcode_out, imm_type_out, pc_out} !==
            {1'b0, 1'b1, CW'(0), 7'h13, 3'b001, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state got v=%b r=%b c=%0d op=%h imm=%b pc=%h exp v=0 r=1 c=0 op=13 imm=001 pc=0",
                     out_valid_out, instr_ready_out, count_out, opcode_out, imm_type_out, pc_out);
        end
`ifdef MSRV32_ILLEGAL_DET_EN
        n_cmp++;
        if (illegal_out !== 1'b0) begin
            n_err++; $display("FAIL reset_illegal got %b exp 0", illegal_out);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        drive(1, 32'h00A0_0093, 32'h0, 0, 0);
        step();
        drive(1, 32'h0011_2223, 32'h4, 0, 0);
        step();
        n_cmp++;
        if ({count_out, instr_ready_out, out_valid_out} !== {CW'(2), 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL fill_full got c=%0d r=%b v=%b exp c=2 r=0 v=1",
                     count_out, instr_ready_out, out_valid_out);
        end
        n_cmp++;
        if ({imm_type_out, rd_addr_out, pc_out} !== {3'b001, 5'd1, 32'h0}) begin
            n_err++;
            $display("FAIL fill_head got imm=%b rd=%0d pc=%h exp imm=001 rd=1 pc=0",
                     imm_type_out, rd_addr_out, pc_out);
        end
        drive(1, 32'hDEAD_BEEF, 32'h99, 0, 0);
        step();
        n_cmp++;
        if ({count_out, pc_out} !== {CW'(2), 32'h0}) begin
            n_err++;
            $display("FAIL fill_reject got c=%0d pc=%h exp c=2 pc=0", count_out, pc_out);
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 0);
        step();
        n_cmp++;
        if ({pc_out, imm_type_out, rs2_addr_out, count_out} !== {32'h4, 3'b010, 5'd1, CW'(1)}) begin
            n_err++;
            $display("FAIL wrap_head1 got pc=%h imm=%b rs2=%0d c=%0d exp pc=4 imm=010 rs2=1 c=1",
                     pc_out, imm_type_out, rs2_addr_out, count_out);
        end
        drive(1, 32'h0000_006F, 32'h8, 0, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        n_cmp++;
        if ({pc_out, imm_type_out, count_out} !== {32'h8, 3'b101, CW'(1)}) begin
            n_err++;
            $display("FAIL wrap_head2 got pc=%h imm=%b c=%0d exp pc=8 imm=101 c=1",
                     pc_out, imm_type_out, count_out);
        end
    endtask

    task automatic test_same_cycle();
        drive(1, 32'h0000_12B7, 32'hC, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if ({count_out, imm_type_out, rd_addr_out, pc_out} !== {CW'(1), 3'b100, 5'd5, 32'hC}) begin
            n_err++;
            $display("FAIL same_cycle got c=%0d imm=%b rd=%0d pc=%h exp c=1 imm=100 rd=5 pc=c",
                     count_out, imm_type_out, rd_addr_out, pc_out);
        end
    endtask

    task automatic test_back_to_back();
        // Full plus pop: the push must still be refused.
        drive(1, 32'h0000_0517, 32'h10, 0, 0);
        step();
        drive(1, 32'h0000_0597, 32'h14, 1, 0);
        step();
        n_cmp++;
        if ({count_out, pc_out} !== {CW'(1), 32'h10}) begin
            n_err++;
            $display("FAIL full_pop_push got c=%0d pc=%h exp c=1 pc=10", count_out, pc_out);
        end
        drive(0, 0, 0, 1, 0);
        step();
        n_cmp++;
        if ({out_valid_out, pc_out, opcode_out} !== {1'b0, 32'h0, 7'h13}) begin
            n_err++;
            $display("FAIL drain_empty got v=%b pc=%h op=%h exp v=0 pc=0 op=13",
                     out_valid_out, pc_out, opcode_out);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h0000_0063, 32'h20, 0, 0);
        step();
        drive(1, 32'h0000_0003, 32'h24, 0, 0);
        step();
        drive(1, 32'h0000_0037, 32'h28, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if ({count_out, out_valid_out, opcode_out, pc_out} !== {CW'(0), 1'b0, 7'h13, 32'h0}) begin
            n_err++;
            $display("FAIL flush_full got c=%0d v=%b op=%h pc=%h exp c=0 v=0 op=13 pc=0",
                     count_out, out_valid_out, opcode_out, pc_out);
        end
        step();
        n_cmp++;
        if (out_valid_out !== 1'b0) begin
            n_err++; $display("FAIL flush_no_ghost got v=%b exp 0", out_valid_out);
        end
        drive(0, 0, 0, 1, 1);
        step();
        drive(1, 32'h0000_0017, 32'h30, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if ({count_out, pc_out, imm_type_out} !== {CW'(1), 32'h30, 3'b100}) begin
            n_err++;
            $display("FAIL flush_empty got c=%0d pc=%h imm=%b exp c=1 pc=30 imm=100",
                     count_out, pc_out, imm_type_out);
        end
        drive(0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
    endtask

`ifdef MSRV32_ILLEGAL_DET_EN
    task automatic test_illegal();
        drive(1, 32'h3052_9073, 32'h40, 0, 0);
        step();
        drive(1, 32'h0000_0000, 32'h44, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if ({illegal_out, imm_type_out} !== {1'b0, 3'b001}) begin
            n_err++;
            $display("FAIL illegal_csrrw got ill=%b imm=%b exp ill=0 imm=001",
                     illegal_out, imm_type_out);
        end
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if ({illegal_out, pc_out} !== {1'b1, 32'h44}) begin
            n_err++;
            $display("FAIL illegal_zero got ill=%b pc=%h exp ill=1 pc=44", illegal_out, pc_out);
        end
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if ({illegal_out, out_valid_out} !== 2'b00) begin
            n_err++;
            $display("FAIL illegal_popped got ill=%b v=%b exp 0 0", illegal_out, out_valid_out);
        end
    endtask
`endif

    task automatic test_random();
        logic [6:0] ops [12];
        logic [31:0] r, w, h;
        logic [VW-1:0] got_v, exp_v;
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F,
                7'h73, 7'h7F};
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            w = {r[31:7], ops[$urandom_range(11)]};
            if ($urandom_range(9) == 0) w[6:0] = r[6:0];
            drive($urandom_range(9) < 7, w, $urandom(), $urandom_range(9) < 6,
                  $urandom_range(19) == 0);
            step();
            h = head_w();
            got_v = {out_valid_out, instr_ready_out, count_out, instr_31_7_out, opcode_out,
                     rd_addr_out, funct3_out, rs1_addr_out, rs2_addr_out, funct7_out,
                     imm_type_out, pc_out};
            exp_v = {q_i.size() != 0, q_i.size() < DEPTH, CW'(q_i.size()), h[31:7], h[6:0],
                     h[11:7], h[14:12], h[19:15], h[24:20], h[31:25], exp_imm(h), head_pc()};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL rand_cycle%0d got %h exp %h", i, got_v, exp_v);
            end
`ifdef MSRV32_ILLEGAL_DET_EN
            n_cmp++;
            if (illegal_out !== exp_illegal(h, q_i.size() != 0)) begin
                n_err++;
                $display("FAIL rand_illegal%0d got %b exp %b", i, illegal_out,
                         exp_illegal(h, q_i.size() != 0));
            end
`endif
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_same_cycle();
        test_back_to_back();
        test_flush();
`ifdef MSRV32_ILLEGAL_DET_EN
        test_illegal();
`endif
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
